lut_divider_2b: RTL and testbench
=================================

Name: lut_divider_2b

Overview:
- Sequential unsigned radix-4 divider; the inverse operation of the team's 2-bit LUT multiplier.
- Each iteration retires 2 quotient bits. It compares the partial remainder against the divisor multiples 1x, 2x (d<<1) and 3x ((d<<1)+d), the same LUT multiples the multiplier uses.
- Sits beside the multiplier in the arithmetic test modules and uses a start/busy/done handshake.

Parameters:
- DIVIDEND_W, 8, dividend and quotient width; must be even and >= 2.
- DIVISOR_W, 4, divisor and remainder width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request a division; sampled on clk
- dividend  input  DIVIDEND_W  unsigned dividend, sampled with start
- divisor  input  DIVISOR_W  unsigned divisor, sampled with start
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse; results valid
- quotient  output  DIVIDEND_W  registered quotient
- remainder  output  DIVISOR_W  registered remainder
- div_err  output  1  only when DIV_ZERO_ERR_EN is defined

Behaviour:
- One clock. Reset is synchronous and active-high. All outputs are registered.
- Reset values: state IDLE, busy=0, done=0, quotient=0, remainder=0, div_err=0.
- States:
  - IDLE, CALC, DONE.
  - In IDLE or DONE, start=1 at edge N latches dividend and divisor, clears the partial remainder R (DIVISOR_W+2 bits) and sets iteration count = DIVIDEND_W/2. Next state is CALC.
  - In CALC, each edge shifts the next 2 dividend MSBs into R, giving P.
  - Digit selection picks q in {3,2,1,0} as the largest q with q*divisor <= P, then sets R = P - q*divisor and shifts q into the quotient LSBs.
  - Multiples are computed at DIVISOR_W+2 bits with no truncation.
  - The last iteration, at edge N+DIVIDEND_W/2, writes quotient and remainder (R[DIVISOR_W-1:0]), sets done=1 and enters DONE.
  - DONE lasts exactly one cycle, then returns to IDLE unless start is accepted there.
- Latency: done is high in the cycle after edge N+DIVIDEND_W/2, which is 4 cycles for the defaults.
- busy is 1 exactly while in CALC. busy and done never overlap.
- start while busy is ignored; operands are not resampled.
- start during the DONE cycle is accepted (back-to-back operation); done still pulses only once.
- quotient and remainder hold their value until the next completion or reset. They are not cleared on start.
- Divisor 0: same latency; quotient = all ones, remainder = 0.
- Reset mid-operation aborts the division. No done pulse is produced, outputs go to their reset values, and the next start works normally.
- Invariant on completion: quotient*divisor + remainder == dividend, and remainder < divisor (for divisor != 0).

Optional Feature:
- Macro: DIV_ZERO_ERR_EN.
- Defined:
  - div_err port exists.
  - div_err=1 in the same cycle as done when the latched divisor was 0; otherwise 0.
  - Holds with the results until the next completion.
- Undefined:
  - No div_err port.
  - Divide-by-zero still produces all-ones quotient and zero remainder, silently.

Decomposition:
- Package lut_div_pkg holds:
  - State encoding constants IDLE/CALC/DONE.
  - Digit width constant (2).
  - Helper width constant for the partial remainder (DIVISOR_W+2).
- One combinational sub-module, lut_div_digit_sel:
  - Inputs: P and divisor.
  - Builds the 1x/2x/3x multiples by shift-and-add.
  - Outputs the 2-bit digit and the next R.
- The top level holds the FSM, counter, shift registers and output registers.

Test Plan:
- dividend=200, divisor=7, start pulse -> busy for 4 cycles, then done for 1 cycle with quotient=28, remainder=4.
- 255/15 -> quotient=17, remainder=0. 5/9 -> quotient=0, remainder=5.
- 77/0 -> quotient=8'hFF, remainder=0, same latency; div_err=1 with DIV_ZERO_ERR_EN, no port without it.
- Start 100/3, then pulse start with 50/2 on the 2nd busy cycle -> second start ignored; quotient=33, remainder=1, single done.
- Start 200/7, assert reset on the 2nd busy cycle -> busy=0, no done, outputs 0. Then start 9/4 -> quotient=2, remainder=1.
- Back-to-back: start 14/3 in the DONE cycle of 200/7 -> first result 28 r4, then 4 r2 exactly 4 cycles later; one done per operation.
- Randomized sweep of all 8-bit dividend / 4-bit divisor pairs, checking the completion invariant.

Source files
------------

// File: rtl/lut_div_pkg.sv
// rtl/lut_div_pkg.sv - shared state encoding and width constants for the radix-4 LUT divider
package lut_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIGIT_W = 2;

  // Partial remainder carries two guard bits so 3x the divisor never truncates.
  function automatic int pr_width(input int divisor_w);
    return divisor_w + DIGIT_W;
  endfunction

endpackage

// File: rtl/lut_div_digit_sel.sv
// rtl/lut_div_digit_sel.sv - picks the largest radix-4 digit q with q*divisor <= P
module lut_div_digit_sel
  import lut_div_pkg::*;
#(
  parameter int DIVISOR_W = 4
) (
  input  logic [DIVISOR_W+DIGIT_W-1:0] p_i,
  input  logic [DIVISOR_W-1:0]         divisor_i,
  output logic [DIGIT_W-1:0]           digit_o,
  output logic [DIVISOR_W+DIGIT_W-1:0] r_next_o
);

  localparam int PR_W = pr_width(DIVISOR_W);

  logic [PR_W-1:0] m1, m2, m3;

  assign m1 = PR_W'(divisor_i);
  assign m2 = m1 << 1;
  assign m3 = m2 + m1;

  // A zero divisor makes every multiple zero, so the digit saturates at 3.
  always_comb begin
    digit_o  = 2'd0;
    r_next_o = p_i;
    if (p_i >= m3) begin
      digit_o  = 2'd3;
      r_next_o = p_i - m3;
    end else if (p_i >= m2) begin
      digit_o  = 2'd2;
      r_next_o = p_i - m2;
    end else if (p_i >= m1) begin
      digit_o  = 2'd1;
      r_next_o = p_i - m1;
    end
  end

endmodule

// File: rtl/lut_divider_2b.sv
// rtl/lut_divider_2b.sv - sequential radix-4 LUT divider with start/busy/done handshake
// Defining DIV_ZERO_ERR_EN adds the div_err output flagging a zero divisor.
module lut_divider_2b
  import lut_div_pkg::*;
#(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder
`ifdef DIV_ZERO_ERR_EN
  ,
  output logic                  div_err
`endif
);

  localparam int PR_W  = pr_width(DIVISOR_W);
  localparam int ITER  = DIVIDEND_W / DIGIT_W;
  localparam int CNT_W = $clog2(ITER + 1);

  div_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [PR_W-1:0]       rem_q, rem_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
  logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
`ifdef DIV_ZERO_ERR_EN
  logic                  err_q, err_d;
`endif

  logic [PR_W-1:0]               p;
  logic [DIGIT_W-1:0]            digit;
  logic [PR_W-1:0]               r_next;
  logic [DIVIDEND_W+DIGIT_W-1:0] quo_wide;
  logic [DIVIDEND_W-1:0]         quo_next;

  assign p        = (rem_q << DIGIT_W) | PR_W'(dvd_q[DIVIDEND_W-1 -: DIGIT_W]);
  assign quo_wide = {quo_q, digit};
  assign quo_next = quo_wide[DIVIDEND_W-1:0];

  lut_div_digit_sel #(
    .DIVISOR_W (DIVISOR_W)
  ) u_digit_sel (
    .p_i       (p),
    .divisor_i (dvs_q),
    .digit_o   (digit),
    .r_next_o  (r_next)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
`ifdef DIV_ZERO_ERR_EN
    err_d       = err_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = CNT_W'(ITER);
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        rem_d = r_next;
        quo_d = quo_next;
        dvd_d = dvd_q << DIGIT_W;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          quotient_d  = quo_next;
          // With a zero divisor R just accumulates dividend bits; report zero instead.
          remainder_d = (dvs_q == '0) ? '0 : r_next[DIVISOR_W-1:0];
`ifdef DIV_ZERO_ERR_EN
          err_d       = (dvs_q == '0);
`endif
          state_d     = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
`ifdef DIV_ZERO_ERR_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
`ifdef DIV_ZERO_ERR_EN
      err_q       <= err_d;
`endif
    end
  end

  assign busy      = (state_q == CALC);
  assign done      = (state_q == DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
`ifdef DIV_ZERO_ERR_EN
  assign div_err   = err_q;
`endif

endmodule

// File: tb/tb_lut_divider_2b.sv
// tb/tb_lut_divider_2b.sv - randomized self-checking bench for lut_divider_2b against an arithmetic model
module tb_lut_divider_2b;

  localparam int ITER = 4;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
`ifdef DIV_ZERO_ERR_EN
  logic       div_err;
`endif

  lut_divider_2b #(
    .DIVIDEND_W (8),
    .DIVISOR_W  (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef DIV_ZERO_ERR_EN
    ,
    .div_err   (div_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Timeline model: an accepted start at edge t0 runs busy after edges t0..t0+ITER-1
  // and completes at edge t0+ITER with plain integer division results.
  int         edge_n   = 0;
  int         m_t0     = 0;
  bit         m_active = 1'b0;
  logic [7:0] m_q, exp_q;
  logic [3:0] m_r, exp_r;
  bit         m_z, exp_e;

  always @(posedge clk) begin
    edge_n++;
    if (reset) begin
      m_active = 1'b0;
      exp_q    = 8'd0;
      exp_r    = 4'd0;
      exp_e    = 1'b0;
    end else begin
      if (m_active && edge_n == m_t0 + ITER) begin
        exp_q = m_q;
        exp_r = m_r;
        exp_e = m_z;
      end
      if (start && !(m_active && edge_n > m_t0 && edge_n <= m_t0 + ITER)) begin
        m_active = 1'b1;
        m_t0     = edge_n;
        if (divisor == 4'd0) begin
          m_q = 8'hFF;
          m_r = 4'd0;
          m_z = 1'b1;
        end else begin
          m_q = dividend / divisor;
          m_r = 4'(dividend % divisor);
          m_z = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_active && edge_n >= m_t0 && edge_n < m_t0 + ITER);
      chk("done", done, m_active && edge_n == m_t0 + ITER);
      chk("quotient", quotient, exp_q);
      chk("remainder", remainder, exp_r);
`ifdef DIV_ZERO_ERR_EN
      chk("div_err", div_err, exp_e);
`endif
      if (done) done_cnt++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic go(input logic [7:0] a, input logic [3:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  task automatic wait_done(input bit noise, output int lat, output int nb);
    lat = 0;
    nb  = 0;
    while (!done && lat < 20) begin
      if (busy) nb++;
      if (noise) begin
        start    = 1'($urandom_range(0, 1));
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
      end
      step();
      lat++;
    end
    start = 1'b0;
    if (lat >= 20) chk("done_timeout", done, 1);
  endtask

  initial begin
    int lat, nb, d0, off, k, prod;
    logic [7:0] a;
    logic [3:0] b;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 4'd0;
    step();
    step();
    chk_en = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    reset = 1'b0;
    step();

    go(8'd200, 4'd7);
    wait_done(1'b0, lat, nb);
    chk("lat_200_7", lat, 4);
    chk("busy_cycles_200_7", nb, 4);
    chk("q_200_7", quotient, 28);
    chk("r_200_7", remainder, 4);
`ifdef DIV_ZERO_ERR_EN
    chk("err_200_7", div_err, 0);
`endif
    step();

    go(8'd255, 4'd15);
    wait_done(1'b0, lat, nb);
    chk("q_255_15", quotient, 17);
    chk("r_255_15", remainder, 0);
    step();
    go(8'd5, 4'd9);
    wait_done(1'b0, lat, nb);
    chk("q_5_9", quotient, 0);
    chk("r_5_9", remainder, 5);
    step();

    go(8'd77, 4'd0);
    wait_done(1'b0, lat, nb);
    chk("lat_77_0", lat, 4);
    chk("q_77_0", quotient, 8'hFF);
    chk("r_77_0", remainder, 0);
`ifdef DIV_ZERO_ERR_EN
    chk("err_77_0", div_err, 1);
`endif
    step();

    d0 = done_cnt;
    go(8'd100, 4'd3);
    step();
    dividend = 8'd50;
    divisor  = 4'd2;
    start    = 1'b1;
    step();
    start = 1'b0;
    wait_done(1'b0, lat, nb);
    chk("q_100_3", quotient, 33);
    chk("r_100_3", remainder, 1);
    repeat (6) step();
    chk("single_done_100_3", done_cnt - d0, 1);

    go(8'd200, 4'd7);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_q", quotient, 0);
    chk("abort_r", remainder, 0);
    d0 = done_cnt;
    repeat (6) step();
    chk("abort_no_done", done_cnt - d0, 0);
    go(8'd9, 4'd4);
    wait_done(1'b0, lat, nb);
    chk("q_9_4", quotient, 2);
    chk("r_9_4", remainder, 1);
    step();

    go(8'd200, 4'd7);
    wait_done(1'b0, lat, nb);
    chk("b2b_q1", quotient, 28);
    chk("b2b_r1", remainder, 4);
    d0 = done_cnt;
    go(8'd14, 4'd3);
    wait_done(1'b0, lat, nb);
    chk("b2b_lat2", lat, 4);
    chk("b2b_q2", quotient, 4);
    chk("b2b_r2", remainder, 2);
    step();
    chk("b2b_one_done", done_cnt - d0, 1);

    off = int'($urandom_range(0, 4095));
    for (int i = 0; i < 4096; i++) begin
      k = (i * 1237 + off) & 4095;
      a = 8'(k >> 4);
      b = 4'(k & 15);
      go(a, b);
      wait_done($urandom_range(0, 3) == 0, lat, nb);
      if (b != 4'd0) begin
        prod = int'(quotient) * int'(b) + int'(remainder);
        chk("inv_qd_plus_r", prod, a);
        chk("inv_r_lt_d", remainder < b, 1);
      end else begin
        chk("sweep_div0_q", quotient, 8'hFF);
        chk("sweep_div0_r", remainder, 0);
      end
      if ($urandom_range(0, 1) == 1) step();
    end

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
